// File: rtl/multdiv_ctrl_if.sv
// Execute-stage <-> multdiv controller signal bundle.
// master: pipeline/multdiv side, slave: multdiv_ctrl.
interface multdiv_ctrl_if;
  logic        ex_valid;
  logic [4:0]  opcode;
  logic [4:0]  ALUop;
  logic [4:0]  rd;
  logic        flush;
  logic        data_resultRDY;
  logic        data_exception;
  logic [31:0] data_result;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic        stall;
  logic        md_we;
  logic [4:0]  md_dest;
  logic [31:0] md_wdata;
  logic [5:0]  busy_cycles;

  modport master (
    output ex_valid, opcode, ALUop, rd, flush,
           data_resultRDY, data_exception, data_result,
    input  ctrl_MULT, ctrl_DIV, stall, md_we, md_dest, md_wdata, busy_cycles
  );

  modport slave (
    input  ex_valid, opcode, ALUop, rd, flush,
           data_resultRDY, data_exception, data_result,
    output ctrl_MULT, ctrl_DIV, stall, md_we, md_dest, md_wdata, busy_cycles
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the multi-cycle mul/div unit: start pulse,
// pipeline stall while busy, single-cycle writeback packet (redirected to
// $r30 with a status code on exception or timeout).
module multdiv_ctrl #(
  parameter int unsigned TIMEOUT  = 40,
  parameter int unsigned MUL_CODE = 4,
  parameter int unsigned DIV_CODE = 5
) (
  input  logic        clock,
  input  logic        reset,
  multdiv_ctrl_if.slave md
);

  localparam logic [5:0]  TMO_LAST = 6'(TIMEOUT - 1);
  localparam logic [5:0]  BUSY_MAX = '1;
  localparam logic [4:0]  RSTATUS  = 5'd30;
  localparam logic [31:0] MUL_WORD = 32'(MUL_CODE);
  localparam logic [31:0] DIV_WORD = 32'(DIV_CODE);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic        is_mul, is_div, is_md;
  logic        start, finish_rdy, finish_tmo;
  logic        lat_mul;
  logic [4:0]  lat_rd;
  logic [5:0]  busy_q;
  logic [4:0]  dest_q;
  logic [31:0] wdata_q;
  logic [31:0] code_word;

  // Decode mul/div R-type in execute
  always_comb begin
    is_mul = md.ex_valid && (md.opcode == 5'd0) && (md.ALUop == 5'd6);
    is_div = md.ex_valid && (md.opcode == 5'd0) && (md.ALUop == 5'd7);
    is_md  = is_mul || is_div;
  end

  assign code_word = lat_mul ? MUL_WORD : DIV_WORD;

  // Next-state and combinational outputs; start is suppressed while reset is
  // asserted so no pulse escapes for an instruction that cannot be accepted.
  always_comb begin
    state_nxt    = state;
    start        = 1'b0;
    finish_rdy   = 1'b0;
    finish_tmo   = 1'b0;
    md.ctrl_MULT = 1'b0;
    md.ctrl_DIV  = 1'b0;
    md.stall     = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_md && !md.flush && reset) begin
          start        = 1'b1;
          md.ctrl_MULT = is_mul;
          md.ctrl_DIV  = is_div;
          md.stall     = 1'b1;
          state_nxt    = BUSY;
        end
      end
      BUSY: begin
        md.stall = 1'b1;
        if (md.flush) begin
          state_nxt = IDLE;
        end else if (md.data_resultRDY) begin
          finish_rdy = 1'b1;
          state_nxt  = DONE;
        end else if (busy_q == TMO_LAST) begin
          finish_tmo = 1'b1;
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operation latch, busy counter and registered writeback packet
  always_ff @(posedge clock) begin
    if (!reset) begin
      lat_mul <= 1'b0;
      lat_rd  <= '0;
      busy_q  <= '0;
      dest_q  <= '0;
      wdata_q <= '0;
    end else begin
      if (start) begin
        lat_mul <= is_mul;
        lat_rd  <= md.rd;
        busy_q  <= '0;
      end else if (state == BUSY && busy_q != BUSY_MAX) begin
        busy_q <= busy_q + 6'd1;
      end
      if (finish_rdy) begin
        if (md.data_exception) begin
          dest_q  <= RSTATUS;
          wdata_q <= code_word;
        end else begin
          dest_q  <= lat_rd;
          wdata_q <= md.data_result;
        end
      end else if (finish_tmo) begin
        dest_q  <= RSTATUS;
        wdata_q <= code_word;
      end
    end
  end

  assign md.md_we       = (state == DONE);
  assign md.md_dest     = dest_q;
  assign md.md_wdata    = wdata_q;
  assign md.busy_cycles = busy_q;

endmodule
